// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
// Operation codes match the OP field driven from the decode-to-execute register.
package ex_muldiv_unit_pkg;

    localparam int unsigned DWL_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide with architectural HI/LO: one result bit per cycle,
// shift-add multiply and restoring divide over one shared 2*DWL-bit accumulator.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned DWL = DWL_DEFAULT,
    parameter int unsigned CW  = 6
) (
    input  logic           CLK,
    input  logic           CLR_N,
    input  logic           START,
    input  logic [1:0]     OP,
    input  logic [DWL-1:0] A,
    input  logic [DWL-1:0] B,
    input  logic           FLUSH,
    input  logic           WE_HI,
    input  logic           WE_LO,
    input  logic [DWL-1:0] WD,
    output logic           BUSY,
    output logic           DONE,
    output logic           DIV0,
    output logic [DWL-1:0] HI,
    output logic [DWL-1:0] LO
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [2*DWL-1:0] acc_q, acc_d;
    logic [DWL-1:0]   opd_q, opd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [DWL-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, div0_q, div0_d;

    logic             signed_op, a_neg, b_neg;
    logic [DWL-1:0]   a_mag, b_mag;
    logic [DWL:0]     mul_sum, div_diff;
    logic [2*DWL-1:0] mul_step, div_step, prod;
    logic [DWL-1:0]   quo, rem;

    assign signed_op = (OP == OP_MULT) || (OP == OP_DIV);
    assign a_neg     = signed_op & A[DWL-1];
    assign b_neg     = signed_op & B[DWL-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum  = {1'b0, acc_q[2*DWL-1:DWL]} + {1'b0, (acc_q[0] ? opd_q : '0)};
    assign mul_step = {mul_sum, acc_q[DWL-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; the extra bit keeps the shifted remainder exact.
    assign div_diff = acc_q[2*DWL-1:DWL-1] - {1'b0, opd_q};
    assign div_step = div_diff[DWL] ? {acc_q[2*DWL-2:0], 1'b0}
                                    : {div_diff[DWL-1:0], acc_q[DWL-2:0], 1'b1};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = acc_q[DWL-1:0];
    assign rem  = acc_q[2*DWL-1:DWL];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (WE_HI) hi_d = WD;
                if (WE_LO) lo_d = WD;
                if (START && !FLUSH) begin
                    state_d = ST_CALC;
                    op_d    = op_e'(OP);
                    cnt_d   = '0;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dz_d    = OP[1] && (B == '0);
                    acc_d   = {{DWL{1'b0}}, (OP[1] ? a_mag : b_mag)};
                    opd_d   = OP[1] ? b_mag : a_mag;
                end
            end
            ST_CALC: begin
                acc_d = op_q[1] ? div_step : mul_step;
                cnt_d = cnt_q + CW'(1);
                if (FLUSH)
                    state_d = ST_IDLE;
                else if (cnt_q == CW'(DWL - 1))
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!FLUSH) begin
                    done_d = 1'b1;
                    div0_d = dz_q;
                    if (op_q[1]) begin
                        // A zero divisor leaves |A| as remainder, so the dividend sign restores A.
                        lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
                        hi_d = rneg_q ? -rem : rem;
                    end else begin
                        hi_d = prod[2*DWL-1:DWL];
                        lo_d = prod[DWL-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULTU;
            acc_q   <= '0;
            opd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign BUSY = (state_q != ST_IDLE);
    assign DONE = done_q;
    assign DIV0 = div0_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed HI/LO results, timing,
// divide-by-zero, overflow, flush, MTHI/MTLO gating and asynchronous reset.
module tb_ex_muldiv_unit;

    logic        CLK, CLR_N, START, FLUSH, WE_HI, WE_LO;
    logic [1:0]  OP;
    logic [31:0] A, B, WD, HI, LO;
    logic        BUSY, DONE, DIV0;

    int n_checks = 0;
    int n_pass   = 0;

    ex_muldiv_unit #(.DWL(32), .CW(6)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .START(START), .OP(OP), .A(A), .B(B),
        .FLUSH(FLUSH), .WE_HI(WE_HI), .WE_LO(WE_LO), .WD(WD),
        .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0), .HI(HI), .LO(LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Issue one operation and wait (bounded) for DONE; returns at the negedge where DONE is high.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles, output bit got_done, output bit div0_seen);
        @(negedge CLK);
        OP = op; A = a; B = b; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        busy_cycles = 0;
        got_done    = 1'b0;
        div0_seen   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (DONE) begin
                got_done  = 1'b1;
                div0_seen = DIV0;
                break;
            end
            if (BUSY) busy_cycles++;
            @(negedge CLK);
        end
    endtask

    int busy;
    bit dn, dz, done_any;

    initial begin
        CLR_N = 1'b0; START = 1'b0; FLUSH = 1'b0; WE_HI = 1'b0; WE_LO = 1'b0;
        OP = 2'b00; A = '0; B = '0; WD = '0;
        repeat (2) @(negedge CLK);
        check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
        check_eq("rst_done", {31'd0, DONE}, 32'd0);
        check_eq("rst_div0", {31'd0, DIV0}, 32'd0);
        check_eq("rst_hi", HI, 32'h0);
        check_eq("rst_lo", LO, 32'h0);
        CLR_N = 1'b1;

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy, dn, dz);
        check_eq("multu_done", {31'd0, dn}, 32'd1);
        check_eq("multu_busy_cycles", busy, 32'd33);
        check_eq("multu_hi", HI, 32'hFFFF_FFFE);
        check_eq("multu_lo", LO, 32'h0000_0001);
        check_eq("multu_div0", {31'd0, dz}, 32'd0);
        @(negedge CLK);
        check_eq("multu_done_pulse", {31'd0, DONE}, 32'd0);

        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, busy, dn, dz);
        check_eq("mult_done", {31'd0, dn}, 32'd1);
        check_eq("mult_hi", HI, 32'hFFFF_FFFF);
        check_eq("mult_lo", LO, 32'hFFFF_FFEB);

        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, busy, dn, dz);
        check_eq("div_done", {31'd0, dn}, 32'd1);
        check_eq("div_lo", LO, 32'hFFFF_FFFD);
        check_eq("div_hi", HI, 32'hFFFF_FFFF);

        do_op(2'b10, 32'd100, 32'd7, busy, dn, dz);
        check_eq("divu_lo", LO, 32'd14);
        check_eq("divu_hi", HI, 32'd2);

        do_op(2'b10, 32'h1234, 32'd0, busy, dn, dz);
        check_eq("div0_done", {31'd0, dn}, 32'd1);
        check_eq("div0_hi", HI, 32'h1234);
        check_eq("div0_lo", LO, 32'hFFFF_FFFF);
        check_eq("div0_flag", {31'd0, dz}, 32'd1);
        @(negedge CLK);
        check_eq("div0_flag_clear", {31'd0, DIV0}, 32'd0);

        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, busy, dn, dz);
        check_eq("ovf_lo", LO, 32'h8000_0000);
        check_eq("ovf_hi", HI, 32'h0);
        check_eq("ovf_div0", {31'd0, dz}, 32'd0);

        // MTHI in idle, then a multiply flushed mid-flight with an MTLO attempted while busy.
        @(negedge CLK);
        WE_HI = 1'b1; WD = 32'hAAAA;
        @(negedge CLK);
        WE_HI = 1'b0;
        check_eq("mthi_idle", HI, 32'hAAAA);
        OP = 2'b00; A = 32'd5; B = 32'd6; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        FLUSH = 1'b1; WE_LO = 1'b1; WD = 32'h5555;
        @(negedge CLK);
        FLUSH = 1'b0; WE_LO = 1'b0;
        check_eq("flush_busy", {31'd0, BUSY}, 32'd0);
        done_any = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (DONE) done_any = 1'b1;
            @(negedge CLK);
        end
        check_eq("flush_no_done", {31'd0, done_any}, 32'd0);
        check_eq("flush_hi", HI, 32'hAAAA);
        check_eq("flush_lo", LO, 32'h8000_0000);

        // Asynchronous reset during a divide.
        OP = 2'b11; A = 32'd1000; B = 32'd3; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (19) @(negedge CLK);
        #2 CLR_N = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, BUSY}, 32'd0);
        check_eq("arst_hi", HI, 32'h0);
        check_eq("arst_lo", LO, 32'h0);
        @(negedge CLK);
        CLR_N = 1'b1;

        // FLUSH beats START.
        @(negedge CLK);
        OP = 2'b00; A = 32'd3; B = 32'd3; START = 1'b1; FLUSH = 1'b1;
        @(negedge CLK);
        START = 1'b0; FLUSH = 1'b0;
        check_eq("start_flush_busy", {31'd0, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);
        check_eq("start_flush_idle", {31'd0, BUSY}, 32'd0);
        check_eq("start_flush_lo", LO, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative 32-bit multiply/divide unit in the EX stage of the pipelined core. It consumes operands and control from the decode-to-execute pipeline register and holds the architectural HI/LO registers. It raises BUSY so the hazard unit can stall the front end, and it drops in-flight work when the pipeline is flushed. It computes one result bit per cycle: shift-add multiply and restoring divide.

## Interface
- DWL, 32, operand and HI/LO width
- CW, 6, iteration counter width (2**CW ≥ DWL)
- CLK  in  1  clock; all state changes on posedge
- CLR_N  in  1  asynchronous, active-low reset
- START  in  1  launch an operation; sampled only in IDLE
- OP  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  in  DWL  rs operand (multiplicand / dividend)
- B  in  DWL  rt operand (multiplier / divisor)
- FLUSH  in  1  synchronous abort (pipeline clear)
- WE_HI, WE_LO  in  1 each  MTHI/MTLO write enables
- WD  in  DWL  MTHI/MTLO write data
- BUSY  out  1  state ≠ IDLE (combinational from state)
- DONE  out  1  one-cycle pulse after HI/LO update
- DIV0  out  1  valid with DONE; divide by zero occurred
- HI, LO  out  DWL each  architectural HI/LO

## Operation
- Reset (CLR_N=0, async): state=IDLE, HI=LO=0, DONE=0, DIV0=0, counter=0, internal datapath=0.
- States:
  - IDLE: START=1 & FLUSH=0 latches OP, |A|, |B| and the result-sign flags, clears the accumulator, counter=0, next state CALC.
  - CALC: one iteration per edge, counter+1. After DWL iterations, next state FIX.
  - FIX: sign correction, HI/LO write, DONE=1, DIV0 set, next state IDLE.
- Signed ops (MULT, DIV) use magnitudes internally.
  - MULT: 2·DWL-bit product is negated if A and B signs differ.
  - DIV: quotient is negated if signs differ; remainder takes the dividend sign. Quotient truncates toward zero.
- Multiply result: {HI,LO} = full 2·DWL-bit product.
- Divide result: LO = quotient, HI = remainder.
- Divide by zero (B=0): HI=A, LO=all ones, DIV0=1, independent of sign. No exception.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV): LO=0x80000000, HI=0. This falls out of the magnitude datapath.
- START while BUSY is ignored. The hazard unit guarantees it is not issued.
- FLUSH=1 in any state forces IDLE on the next edge:
  - HI/LO are unchanged and no DONE pulse occurs.
  - FLUSH beats START in the same cycle.
  - FLUSH during FIX suppresses the write.
- WE_HI/WE_LO write WD only when BUSY=0. Writes while BUSY are dropped.
  - A write in the same IDLE cycle as an accepted START lands. The result later overwrites it.
- DONE and DIV0 are registered and are 0 in every cycle except the one following the FIX edge.

## Timing
- E0 = edge sampling START=1 in IDLE.
- CALC iterations on edges E1..E_DWL.
- FIX edge E_(DWL+1) writes HI/LO. New values are visible from that edge, and DONE is high for that cycle.
- BUSY is high for DWL+1 cycles, from after E0 until E_(DWL+1).
- Throughput: a new START is accepted in the DONE cycle at the earliest (state is IDLE). Back-to-back ops take DWL+2 cycles each.
- Reset mid-operation aborts immediately, asynchronously, to the reset values.

## Structure
- The shared package holds:
  - OP encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
  - the state encoding (ST_IDLE, ST_CALC, ST_FIX)
  - DWL default
- Single module; no sub-module required. Magnitude conversion and sign fix-up are inline.
- One shared 2·DWL-bit accumulator serves both multiply (product) and divide (remainder:quotient shift register).

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 34 edges HI=0xFFFFFFFE, LO=0x00000001; DONE one cycle; BUSY 33 cycles.
- MULT A=-3 (0xFFFFFFFD), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=0x1234, B=0 -> HI=0x1234, LO=0xFFFFFFFF, DIV0=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, DIV0=0.
- MTHI 0xAAAA in IDLE, then MULTU 5×6; FLUSH at E10 -> HI=0xAAAA, LO unchanged, no DONE. MTLO during BUSY is dropped.
- CLR_N low at E20 of a DIV -> HI=LO=0, BUSY=0 immediately. START with FLUSH together -> stays IDLE.
